tmboc_acq_corr: RTL and testbench

TMBOC_ACQ_CORR -- requirements
Module: tmboc_acq_corr

---
 rtl/tmboc_acq_corr_pkg.sv | 13 +
 rtl/tmboc_acq_corr_sat_add.sv | 23 ++
 rtl/tmboc_acq_corr.sv | 160 ++++++++++++++++
 tb/tb_tmboc_acq_corr.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmboc_acq_corr_pkg.sv
// Shared B1 acquisition definitions: default widths and the coherent-accumulation FSM encoding.
package tmboc_acq_corr_pkg;

  localparam int SAMPLE_WIDTH_DEF  = 8;
  localparam int CORR_WIDTH_DEF    = 24;
  localparam int PRN_PHS_WIDTH_DEF = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acq_state_t;

endpackage

// File: rtl/tmboc_acq_corr_sat_add.sv
// Signed saturating adder: the result clamps to the representable range instead of wrapping.
module tmboc_acq_corr_sat_add
  import tmboc_acq_corr_pkg::*;
#(
  parameter int WIDTH = CORR_WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] sum_ext;

  assign sum_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign y       = sat_w(sum_ext);

endmodule

// File: rtl/tmboc_acq_corr.sv
// TMBOC coherent acquisition correlator: wipes the local code off I/Q over one PRN period,
// then squares and sums the result into an energy value behind a valid/ready holding register.
module tmboc_acq_corr
  import tmboc_acq_corr_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
  parameter int CORR_WIDTH    = CORR_WIDTH_DEF,
  parameter int PRN_PHS_WIDTH = PRN_PHS_WIDTH_DEF
) (
  input  logic                            rx_clk,
  input  logic                            rx_rst,
  input  logic                            rx_en,
  input  logic signed [SAMPLE_WIDTH-1:0]  rx_samp_i,
  input  logic signed [SAMPLE_WIDTH-1:0]  rx_samp_q,
  input  logic                            rx_loc_code,
  input  logic                            rx_prn_sop,
  input  logic                            rx_prn_eop,
  input  logic                            rx_corr_ready,
  output logic signed [CORR_WIDTH-1:0]    tx_corr_i,
  output logic signed [CORR_WIDTH-1:0]    tx_corr_q,
  output logic        [2*CORR_WIDTH:0]    tx_corr_energy,
  output logic        [PRN_PHS_WIDTH-1:0] tx_corr_len,
  output logic                            tx_corr_valid,
  output logic                            tx_corr_ovf
);

  localparam int SQ_W = 2 * CORR_WIDTH;

  function automatic logic [SQ_W-1:0] square(input logic signed [CORR_WIDTH-1:0] v);
    logic signed [SQ_W-1:0] e;
    e = {{CORR_WIDTH{v[CORR_WIDTH-1]}}, v};
    return $unsigned(e * e);
  endfunction

  acq_state_t state_q, state_d;
  logic load, accum, done;

  logic signed [CORR_WIDTH-1:0] ext_i, ext_q, term_i, term_q;
  logic signed [CORR_WIDTH-1:0] acc_i, acc_q, sum_i, sum_q, nxt_i, nxt_q;
  logic        [PRN_PHS_WIDTH-1:0] cnt, cnt_nxt;

  logic signed [CORR_WIDTH-1:0]    i_p0, q_p0, i_p1, q_p1;
  logic        [PRN_PHS_WIDTH-1:0] len_p0, len_p1;
  logic        [SQ_W-1:0]          sq_i_p1, sq_q_p1;
  logic                            vld_p0, vld_p1;

  // Code wipe-off: chip 1 is -1, so the sample is negated after widening.
  assign ext_i  = {{(CORR_WIDTH-SAMPLE_WIDTH){rx_samp_i[SAMPLE_WIDTH-1]}}, rx_samp_i};
  assign ext_q  = {{(CORR_WIDTH-SAMPLE_WIDTH){rx_samp_q[SAMPLE_WIDTH-1]}}, rx_samp_q};
  assign term_i = rx_loc_code ? -ext_i : ext_i;
  assign term_q = rx_loc_code ? -ext_q : ext_q;

  tmboc_acq_corr_sat_add #(.WIDTH(CORR_WIDTH)) sat_add_i (.a(acc_i), .b(term_i), .y(sum_i));
  tmboc_acq_corr_sat_add #(.WIDTH(CORR_WIDTH)) sat_add_q (.a(acc_q), .b(term_q), .y(sum_q));

  assign nxt_i   = load ? term_i : sum_i;
  assign nxt_q   = load ? term_q : sum_q;
  assign cnt_nxt = load ? PRN_PHS_WIDTH'(1) : (&cnt ? cnt : cnt + PRN_PHS_WIDTH'(1));

  always_ff @(posedge rx_clk) begin
    if (rx_rst) state_q <= IDLE;
    else if (rx_en) state_q <= state_d;
  end

  // sop restarts from any state; eop only closes a period that is open (or opening now).
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accum   = 1'b0;
    done    = 1'b0;
    if (rx_en) begin
      if (rx_prn_sop) begin
        load    = 1'b1;
        done    = rx_prn_eop;
        state_d = rx_prn_eop ? IDLE : ACCUM;
      end else if (state_q == ACCUM) begin
        accum = 1'b1;
        if (rx_prn_eop) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      acc_i <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else if (load || accum) begin
      acc_i <= nxt_i;
      acc_q <= nxt_q;
      cnt   <= cnt_nxt;
    end
  end

  // p0: capture the completed period, including the eop sample.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      vld_p0 <= 1'b0;
      i_p0   <= '0;
      q_p0   <= '0;
      len_p0 <= '0;
    end else if (rx_en) begin
      vld_p0 <= done;
      if (done) begin
        i_p0   <= nxt_i;
        q_p0   <= nxt_q;
        len_p0 <= cnt_nxt;
      end
    end
  end

  // p1: squares.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      vld_p1  <= 1'b0;
      i_p1    <= '0;
      q_p1    <= '0;
      len_p1  <= '0;
      sq_i_p1 <= '0;
      sq_q_p1 <= '0;
    end else if (rx_en) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        i_p1    <= i_p0;
        q_p1    <= q_p0;
        len_p1  <= len_p0;
        sq_i_p1 <= square(i_p0);
        sq_q_p1 <= square(q_p0);
      end
    end
  end

  // Output holding register: loads when empty or being accepted, otherwise drops and flags.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      tx_corr_valid  <= 1'b0;
      tx_corr_ovf    <= 1'b0;
      tx_corr_i      <= '0;
      tx_corr_q      <= '0;
      tx_corr_len    <= '0;
      tx_corr_energy <= '0;
    end else if (rx_en) begin
      if (!tx_corr_valid || rx_corr_ready) begin
        tx_corr_valid <= vld_p1;
        if (vld_p1) begin
          tx_corr_i      <= i_p1;
          tx_corr_q      <= q_p1;
          tx_corr_len    <= len_p1;
          tx_corr_energy <= {1'b0, sq_i_p1} + {1'b0, sq_q_p1};
        end
      end else if (vld_p1) begin
        tx_corr_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmboc_acq_corr.sv
// Scoreboard bench for tmboc_acq_corr: a default-width instance plus a narrow instance for saturation.
module tb_tmboc_acq_corr;

  localparam int SW  = 8;
  localparam int CW  = 24;
  localparam int LW  = 15;
  localparam int CW2 = 12;
  localparam int LW2 = 6;

  logic rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  logic rx_rst, en1, en2, code, sop, eop, ready;
  logic signed [SW-1:0] si, sq;

  logic signed [CW-1:0]  o_i, o_q;
  logic        [2*CW:0]  o_e;
  logic        [LW-1:0]  o_len;
  logic                  o_vld, o_ovf;
  logic signed [CW2-1:0] o2_i, o2_q;
  logic        [2*CW2:0] o2_e;
  logic        [LW2-1:0] o2_len;
  logic                  o2_vld, o2_ovf;

  tmboc_acq_corr dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_en(en1),
    .rx_samp_i(si), .rx_samp_q(sq), .rx_loc_code(code),
    .rx_prn_sop(sop), .rx_prn_eop(eop), .rx_corr_ready(ready),
    .tx_corr_i(o_i), .tx_corr_q(o_q), .tx_corr_energy(o_e),
    .tx_corr_len(o_len), .tx_corr_valid(o_vld), .tx_corr_ovf(o_ovf)
  );

  tmboc_acq_corr #(.SAMPLE_WIDTH(SW), .CORR_WIDTH(CW2), .PRN_PHS_WIDTH(LW2)) dut_sat (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_en(en2),
    .rx_samp_i(si), .rx_samp_q(sq), .rx_loc_code(code),
    .rx_prn_sop(sop), .rx_prn_eop(eop), .rx_corr_ready(ready),
    .tx_corr_i(o2_i), .tx_corr_q(o2_q), .tx_corr_energy(o2_e),
    .tx_corr_len(o2_len), .tx_corr_valid(o2_vld), .tx_corr_ovf(o2_ovf)
  );

  typedef struct {
    longint i;
    longint q;
    longint len;
  } res_t;

  res_t   exp0[$], exp1[$];
  res_t   r0, r1;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint m_i[2], m_q[2], m_len[2];
  bit     m_act[2];

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference model of one instance for the sample currently on the inputs.
  task automatic model_inst(input int k, input bit en, input int cw, input int lw);
    longint ti, tq;
    res_t   r;
    if (!en) return;
    ti = code ? -longint'(si) : longint'(si);
    tq = code ? -longint'(sq) : longint'(sq);
    if (sop) begin
      m_i[k] = ti; m_q[k] = tq; m_len[k] = 1; m_act[k] = 1'b1;
    end else if (m_act[k]) begin
      m_i[k]   = clamp(m_i[k] + ti, cw);
      m_q[k]   = clamp(m_q[k] + tq, cw);
      m_len[k] = (m_len[k] == (longint'(1) <<< lw) - 1) ? m_len[k] : m_len[k] + 1;
    end
    if (eop && m_act[k]) begin
      r.i = m_i[k]; r.q = m_q[k]; r.len = m_len[k];
      if (k == 0) exp0.push_back(r);
      else exp1.push_back(r);
      m_act[k] = 1'b0;
    end
  endtask

  task automatic step();
    if (rx_rst) begin
      m_act[0] = 1'b0; m_act[1] = 1'b0;
      exp0.delete(); exp1.delete();
    end else begin
      model_inst(0, en1, CW, LW);
      model_inst(1, en2, CW2, LW2);
    end
    @(posedge rx_clk); #1;
  endtask

  task automatic samp(input int vi, input int vq, input bit c, input bit s, input bit e);
    si = vi[SW-1:0]; sq = vq[SW-1:0]; code = c; sop = s; eop = e;
    step();
    sop = 1'b0; eop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  always @(negedge rx_clk) begin
    if (!rx_rst && en1 && o_vld && ready) begin
      if (exp0.size() == 0) chk("m0_unexpected_valid", o_vld, 0);
      else begin
        r0 = exp0.pop_front();
        chk("m0_i", $signed(o_i), r0.i);
        chk("m0_q", $signed(o_q), r0.q);
        chk("m0_len", o_len, r0.len);
        chk("m0_energy", o_e, r0.i * r0.i + r0.q * r0.q);
      end
    end
    if (!rx_rst && en2 && o2_vld && ready) begin
      if (exp1.size() == 0) chk("m1_unexpected_valid", o2_vld, 0);
      else begin
        r1 = exp1.pop_front();
        chk("m1_i", $signed(o2_i), r1.i);
        chk("m1_q", $signed(o2_q), r1.q);
        chk("m1_len", o2_len, r1.len);
        chk("m1_energy", o2_e, r1.i * r1.i + r1.q * r1.q);
      end
    end
  end

  initial begin
    rx_rst = 1'b1; en1 = 1'b1; en2 = 1'b0; code = 1'b0; sop = 1'b0; eop = 1'b0;
    ready = 1'b1; si = '0; sq = '0;
    idle(3);
    chk("rst_valid", o_vld, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_i", $signed(o_i), 0);
    chk("rst_len", o_len, 0);
    chk("rst_energy", o_e, 0);
    chk("rst2_valid", o2_vld, 0);
    rx_rst = 1'b0;
    idle(2);

    // Four samples, codes 0,0,1,0: result appears exactly three cycles after eop.
    samp(10, -7, 0, 1, 0);
    samp(10, -7, 0, 0, 0);
    samp(10, -7, 1, 0, 0);
    samp(10, -7, 0, 0, 1);
    idle(1);
    chk("s1_valid_eop2", o_vld, 0);
    idle(1);
    chk("s1_valid_eop3", o_vld, 1);
    chk("s1_i", $signed(o_i), 20);
    chk("s1_len", o_len, 4);
    chk("s1_energy", o_e, 596);
    idle(2);

    // sop and eop together.
    samp(-5, 3, 1, 1, 1);
    idle(2);
    chk("s2_valid", o_vld, 1);
    chk("s2_i", $signed(o_i), 5);
    chk("s2_q", $signed(o_q), -3);
    chk("s2_len", o_len, 1);
    chk("s2_energy", o_e, 34);
    idle(2);

    // Back-to-back random periods.
    for (int p = 0; p < 4; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        samp($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
             $urandom_range(0, 1), k == 0, k == len - 1);
    end
    idle(4);

    // Restart mid-period discards the partial sum.
    for (int k = 0; k < 7; k++) samp(20, 1, 0, k == 0, 0);
    samp(1, 2, 0, 1, 0);
    samp(3, 4, 1, 0, 0);
    samp(5, 6, 0, 0, 1);
    idle(2);
    chk("s4_len", o_len, 3);
    chk("s4_i", $signed(o_i), 3);
    chk("s4_energy", o_e, 25);
    idle(2);

    // eop and samples in IDLE are ignored; rx_en low pauses accumulation and pipeline.
    samp(9, 9, 0, 0, 1);
    samp(9, 9, 0, 0, 0);
    samp(4, -4, 0, 1, 0);
    en1 = 1'b0;
    samp(100, 100, 0, 1, 1);
    samp(100, 100, 1, 0, 1);
    en1 = 1'b1;
    samp(4, -4, 0, 0, 1);
    idle(1);
    en1 = 1'b0;
    idle(5);
    chk("s5_hold_valid", o_vld, 0);
    en1 = 1'b1;
    idle(1);
    chk("s5_valid", o_vld, 1);
    chk("s5_i", $signed(o_i), 8);
    idle(2);

    // New result arriving on the acceptance cycle replaces the held one without overflow.
    ready = 1'b0;
    samp(7, 0, 0, 1, 1);
    idle(3);
    chk("s6_held_valid", o_vld, 1);
    idle(2);
    chk("s6_held_i", $signed(o_i), 7);
    samp(-9, 2, 0, 1, 1);
    idle(1);
    ready = 1'b1;
    idle(1);
    chk("s6_valid", o_vld, 1);
    chk("s6_i", $signed(o_i), -9);
    chk("s6_ovf", o_ovf, 0);
    idle(1);
    chk("s6_clear", o_vld, 0);

    // Second result dropped while the first is held.
    ready = 1'b0;
    samp(11, 0, 0, 1, 0);
    samp(11, 0, 0, 0, 1);
    samp(-3, 1, 0, 1, 0);
    samp(-3, 1, 0, 0, 1);
    void'(exp0.pop_back());
    idle(6);
    chk("s7_valid", o_vld, 1);
    chk("s7_ovf", o_ovf, 1);
    chk("s7_i", $signed(o_i), 22);
    chk("s7_len", o_len, 2);
    ready = 1'b1;
    idle(1);
    chk("s7_clear", o_vld, 0);
    chk("s7_ovf_sticky", o_ovf, 1);
    idle(2);

    // Reset at eop+1 discards the in-flight result.
    samp(12, 12, 0, 1, 0);
    samp(12, 12, 0, 0, 1);
    rx_rst = 1'b1;
    step();
    rx_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("s8_no_valid", o_vld, 0);
    end
    chk("s8_ovf", o_ovf, 0);
    chk("s8_i", $signed(o_i), 0);
    chk("s8_energy", o_e, 0);
    samp(5, 5, 0, 1, 0);
    rx_rst = 1'b1;
    samp(5, 5, 0, 0, 0);
    rx_rst = 1'b0;
    samp(5, 5, 0, 0, 1);
    idle(4);
    chk("s8_mid_no_valid", o_vld, 0);

    // Saturation on the narrow instance: 100 samples of +127 / -128.
    en1 = 1'b0;
    en2 = 1'b1;
    samp(127, -128, 0, 1, 0);
    for (int k = 0; k < 98; k++) samp(127, -128, 0, 0, 0);
    samp(127, -128, 0, 0, 1);
    idle(2);
    chk("s9_valid", o2_vld, 1);
    chk("s9_i_sat", $signed(o2_i), 2047);
    chk("s9_q_sat", $signed(o2_q), -2048);
    chk("s9_len_sat", o2_len, 63);
    idle(2);
    samp(-128, 0, 1, 1, 1);
    idle(4);
    en2 = 1'b0;
    en1 = 1'b1;

    for (int k = 0; k < 50; k++) begin
      if (exp0.size() == 0 && exp1.size() == 0) break;
      idle(1);
    end
    chk("drain_pending", exp0.size() + exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
